// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between pipeline WB and the MUL/DIV unit,
// tracks outstanding MDU destinations for RAW hazard detection and bounds MDU starvation.
`default_nettype none

module rf_write_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        hazard,
  output logic        wb_stall,
  output logic [31:0] pending,
  output logic        rf_we,
  output logic [4:0]  rf_rw,
  output logic [31:0] rf_busW
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FORCE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic             w_wb_act, w_xfer, w_blocked;
  logic [31:0]      w_pending_nxt;

  assign wb_stall  = (r_state == S_FORCE);
  assign w_wb_act  = wb_we && (wb_rd != 5'd0) && !wb_stall;
  assign mdu_ready = !rst && mdu_valid && ((r_state == S_FORCE) || !w_wb_act);
  assign w_xfer    = mdu_valid && mdu_ready;
  assign w_blocked = mdu_valid && !mdu_ready;

  assign hazard = ((rs1 != 5'd0) && pending[rs1]) || ((rs2 != 5'd0) && pending[rs2]);

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_blocked) begin
          if (MAX_WAIT == 1) begin
            w_state_nxt    = S_FORCE;
            w_wait_cnt_nxt = '0;
          end else begin
            w_state_nxt    = S_WAIT;
            w_wait_cnt_nxt = CNT_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (w_xfer || !mdu_valid) begin
          w_state_nxt    = S_IDLE;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
          w_state_nxt    = S_FORCE;
          w_wait_cnt_nxt = '0;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
        end
      end
      S_FORCE: begin
        w_state_nxt    = S_IDLE;
        w_wait_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  // Set after clear so a same-cycle reissue of the destination stays pending.
  always_comb begin
    w_pending_nxt = pending;
    if (w_xfer) w_pending_nxt[mdu_rd] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0)) w_pending_nxt[issue_rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      pending    <= '0;
      rf_we      <= 1'b0;
      rf_rw      <= 5'd0;
      rf_busW    <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      pending    <= w_pending_nxt;
      if (w_xfer) begin
        rf_we   <= (mdu_rd != 5'd0);
        rf_rw   <= mdu_rd;
        rf_busW <= mdu_data;
      end else if (w_wb_act) begin
        rf_we   <= 1'b1;
        rf_rw   <= wb_rd;
        rf_busW <= wb_data;
      end else begin
        rf_we <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter (MAX_WAIT=4).
`default_nettype none

module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1, rs2;
  logic        hazard, wb_stall;
  logic [31:0] pending;
  logic        rf_we;
  logic [4:0]  rf_rw;
  logic [31:0] rf_busW;

  int n_checks = 0;
  int n_fail   = 0;

  rf_write_arbiter #(.MAX_WAIT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .hazard(hazard), .wb_stall(wb_stall), .pending(pending),
    .rf_we(rf_we), .rf_rw(rf_rw), .rf_busW(rf_busW)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_we = 0; wb_rd = 0; wb_data = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
    issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    #1;

    // 1. Reset with inputs toggling; last reset cycle carries a WB write
    for (int i = 0; i < 2; i++) begin
      wb_we = 1; wb_rd = 5'd5 + 5'(i); wb_data = 32'hAAAA0000 + i;
      mdu_valid = 1; mdu_rd = 5'd9; mdu_data = 32'h1111;
      issue_valid = 1; issue_rd = 5'd3; rs1 = 5'd3; rs2 = 5'd9;
      #1;
      check("rst_mdu_ready", {31'd0, mdu_ready}, 32'd0);
      tick();
      check("rst_rf_we", {31'd0, rf_we}, 32'd0);
      check("rst_rf_rw", {27'd0, rf_rw}, 32'd0);
      check("rst_rf_busW", rf_busW, 32'd0);
      check("rst_pending", pending, 32'd0);
      check("rst_wb_stall", {31'd0, wb_stall}, 32'd0);
    end
    rst = 0;
    idle_inputs();
    tick();
    check("post_rst_no_write", {31'd0, rf_we}, 32'd0);

    // 2. WB only
    wb_we = 1; wb_rd = 5'd5; wb_data = 32'h00001234;
    tick();
    check("wb_rf_we", {31'd0, rf_we}, 32'd1);
    check("wb_rf_rw", {27'd0, rf_rw}, 32'd5);
    check("wb_rf_busW", rf_busW, 32'h00001234);
    wb_rd = 5'd0; wb_data = 32'hFFFF;
    tick();
    check("wb_x0_rf_we", {31'd0, rf_we}, 32'd0);
    check("wb_x0_hold_rw", {27'd0, rf_rw}, 32'd5);
    check("wb_x0_hold_busW", rf_busW, 32'h00001234);
    wb_we = 0;

    // 3. MDU path with scoreboard
    issue_valid = 1; issue_rd = 5'd7;
    tick();
    issue_valid = 0; issue_rd = 0;
    check("issue7_pending", pending, 32'h00000080);
    rs1 = 5'd7; #1;
    check("issue7_hazard", {31'd0, hazard}, 32'd1);
    mdu_valid = 1; mdu_rd = 5'd7; mdu_data = 32'hDEADBEEF; #1;
    check("mdu_ready_free", {31'd0, mdu_ready}, 32'd1);
    tick();
    mdu_valid = 0;
    check("mdu_rf_we", {31'd0, rf_we}, 32'd1);
    check("mdu_rf_rw", {27'd0, rf_rw}, 32'd7);
    check("mdu_rf_busW", rf_busW, 32'hDEADBEEF);
    check("mdu_pending_clr", pending, 32'd0);
    check("mdu_hazard_clr", {31'd0, hazard}, 32'd0);
    rs1 = 0;

    // 4. Starvation: blocked 4 cycles, forced slot on cycle 5
    wb_we = 1; wb_rd = 5'd3; wb_data = 32'h00000333;
    mdu_valid = 1; mdu_rd = 5'd9; mdu_data = 32'h55;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check($sformatf("starve_ready_c%0d", c), {31'd0, mdu_ready}, 32'd0);
      check($sformatf("starve_stall_c%0d", c), {31'd0, wb_stall}, 32'd0);
      tick();
      check($sformatf("starve_wb_rw_c%0d", c), {27'd0, rf_rw}, 32'd3);
    end
    #1;
    check("force_stall", {31'd0, wb_stall}, 32'd1);
    check("force_ready", {31'd0, mdu_ready}, 32'd1);
    tick();
    mdu_valid = 0;
    check("force_rf_we", {31'd0, rf_we}, 32'd1);
    check("force_rf_rw", {27'd0, rf_rw}, 32'd9);
    check("force_rf_busW", rf_busW, 32'h55);
    check("force_stall_off", {31'd0, wb_stall}, 32'd0);
    tick();
    check("resume_wb_rw", {27'd0, rf_rw}, 32'd3);
    check("resume_wb_busW", rf_busW, 32'h00000333);
    check("resume_wb_we", {31'd0, rf_we}, 32'd1);

    // 5. Corner cases
    wb_rd = 5'd0; mdu_valid = 1; mdu_rd = 5'd10; mdu_data = 32'h0000000A; #1;
    check("x0_wb_mdu_ready", {31'd0, mdu_ready}, 32'd1);
    tick();
    check("x0_wb_mdu_rw", {27'd0, rf_rw}, 32'd10);
    check("x0_wb_mdu_busW", rf_busW, 32'h0000000A);
    wb_we = 0;
    mdu_rd = 5'd0; mdu_data = 32'h99;
    tick();
    check("mdu_x0_rf_we", {31'd0, rf_we}, 32'd0);
    mdu_valid = 0;
    issue_valid = 1; issue_rd = 5'd2;
    tick();
    issue_rd = 5'd0;
    tick();
    issue_valid = 0;
    check("issue_x0_pending", pending, 32'h00000004);
    rs1 = 0; rs2 = 0; #1;
    check("rs_zero_hazard", {31'd0, hazard}, 32'd0);
    rs2 = 5'd2; #1;
    check("rs2_hazard", {31'd0, hazard}, 32'd1);
    rs2 = 0;
    issue_valid = 1; issue_rd = 5'd4;
    mdu_valid = 1; mdu_rd = 5'd4; mdu_data = 32'h44;
    tick();
    issue_valid = 0; mdu_valid = 0;
    check("set_wins_pending", pending, 32'h00000014);
    check("set_wins_rf_rw", {27'd0, rf_rw}, 32'd4);

    // 6. Reset while waiting with wait_cnt=2
    issue_valid = 1; issue_rd = 5'd9;
    tick();
    issue_valid = 0;
    check("pre_rst_pending", pending, 32'h00000214);
    wb_we = 1; wb_rd = 5'd3; wb_data = 32'h333;
    mdu_valid = 1; mdu_rd = 5'd9; mdu_data = 32'h99;
    tick();
    tick();
    rst = 1; #1;
    check("midrst_ready", {31'd0, mdu_ready}, 32'd0);
    tick();
    check("midrst_stall", {31'd0, wb_stall}, 32'd0);
    check("midrst_pending", pending, 32'd0);
    check("midrst_rf_we", {31'd0, rf_we}, 32'd0);
    rst = 0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check($sformatf("postrst_stall_c%0d", c), {31'd0, wb_stall}, 32'd0);
      check($sformatf("postrst_ready_c%0d", c), {31'd0, mdu_ready}, 32'd0);
      tick();
    end
    check("postrst_force", {31'd0, wb_stall}, 32'd1);
    tick();
    check("postrst_rf_rw", {27'd0, rf_rw}, 32'd9);
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
